// File: rtl/vae_recon_collector.sv
// Applies a pattern to the autoencoder, averages NUM_SAMPLES stochastic output
// vectors, thresholds them back to a 9-bit reconstruction and counts bit errors.
module vae_recon_collector #(
    parameter int                 NUM_SAMPLES   = 8,
    parameter int                 SETTLE_CYCLES = 2,
    parameter logic signed [19:0] THRESH        = 20'sh08000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8:0]          x_ref,
    input  logic signed [19:0]  y_0,
    input  logic signed [19:0]  y_1,
    input  logic signed [19:0]  y_2,
    input  logic signed [19:0]  y_3,
    input  logic signed [19:0]  y_4,
    input  logic signed [19:0]  y_5,
    input  logic signed [19:0]  y_6,
    input  logic signed [19:0]  y_7,
    input  logic signed [19:0]  y_8,
    output logic [8:0]          x_drive,
    output logic                busy,
    output logic                done,
    output logic [8:0]          x_hat,
    output logic [3:0]          err_count,
    output logic [179:0]        p_avg
);

    localparam int DATA_W = 20;
    localparam int NOUT   = 9;
    localparam int ACC_W  = 23;
    localparam int CLP_W  = 17;
    localparam int SHIFT  = $clog2(NUM_SAMPLES);
    localparam int CNT_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [DATA_W-1:0]  w_y [NOUT];
    logic [ACC_W-1:0]          r_acc [NOUT];
    logic [3:0]                r_settle_cnt;
    logic [CNT_W-1:0]          r_sample_cnt;
    logic [8:0]                r_ref;
    logic [8:0]                r_x_drive;
    logic [8:0]                r_x_hat;
    logic [3:0]                r_err;
    logic [179:0]              r_p_avg;
    logic [DATA_W-1:0]         w_avg [NOUT];
    logic [8:0]                w_x_hat;
    logic [3:0]                w_err;

    // Sigmoid outputs can stray outside [0, 1.0]; pin them to that range.
    function automatic logic [CLP_W-1:0] clamp_unit(input logic signed [DATA_W-1:0] v);
        if (v < 20'sd0)
            return '0;
        else if (v > 20'sh10000)
            return 17'h10000;
        else
            return v[CLP_W-1:0];
    endfunction

    assign w_y[0] = y_0;
    assign w_y[1] = y_1;
    assign w_y[2] = y_2;
    assign w_y[3] = y_3;
    assign w_y[4] = y_4;
    assign w_y[5] = y_5;
    assign w_y[6] = y_6;
    assign w_y[7] = y_7;
    assign w_y[8] = y_8;

    assign x_drive   = r_x_drive;
    assign x_hat     = r_x_hat;
    assign err_count = r_err;
    assign p_avg     = r_p_avg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (r_settle_cnt == 4'd0)
                    w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (r_sample_cnt == CNT_W'(NUM_SAMPLES - 1))
                    w_state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Average is a plain shift because NUM_SAMPLES is a power of two.
    always_comb begin
        w_avg   = '{default: '0};
        w_x_hat = '0;
        w_err   = '0;
        for (int i = 0; i < NOUT; i++) begin
            w_avg[i]       = DATA_W'(r_acc[i] >> SHIFT);
            w_x_hat[8 - i] = ($signed(w_avg[i]) >= THRESH);
        end
        for (int i = 0; i < NOUT; i++)
            w_err = w_err + {3'd0, w_x_hat[i] ^ r_ref[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOUT; i++)
                r_acc[i] <= '0;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_ref        <= '0;
            r_x_drive    <= '0;
            r_x_hat      <= '0;
            r_err        <= '0;
            r_p_avg      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ref        <= x_ref;
                        r_x_drive    <= x_ref;
                        r_settle_cnt <= 4'(SETTLE_CYCLES - 1);
                        for (int i = 0; i < NOUT; i++)
                            r_acc[i] <= '0;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt != 4'd0)
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    else
                        r_sample_cnt <= '0;
                end
                S_ACCUM: begin
                    for (int i = 0; i < NOUT; i++)
                        r_acc[i] <= r_acc[i] + {{(ACC_W - CLP_W){1'b0}}, clamp_unit(w_y[i])};
                    r_sample_cnt <= r_sample_cnt + 1'b1;
                end
                S_DECIDE: begin
                    r_x_hat <= w_x_hat;
                    r_err   <= w_err;
                    for (int i = 0; i < NOUT; i++)
                        r_p_avg[DATA_W*i +: DATA_W] <= w_avg[i];
                end
                default: ;
            endcase
        end
    end

endmodule
